uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Frame-level round-robin arbiter that shares the UART transmit FIFO write port (wr_uart / w_data / tx_full of top_uart) among several requesters. It grants one requester at a time and holds the grant until that requester's frame completes, so bytes from different frames never interleave. It sits between the per-client transmit sources and the top_uart write interface.

## Interface
- n_req, 4: number of requesters (2..8)
- n_data_bits, 8: byte width; matches top_uart
- n_timeout, 10: stall-counter width (used only with UART_ARB_TIMEOUT_EN)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  n_req  requester i has a frame pending; held high until its last byte transfers
- req_valid  in  n_req  requester i presents a byte
- req_data  in  n_req*n_data_bits  flattened bytes; requester i at bits [i*n_data_bits +: n_data_bits]
- req_last  in  n_req  the presented byte is the last of the frame
- req_ready  out  n_req  byte from requester i accepted this cycle if valid
- grant  out  n_req  one-hot current owner; all zero when idle
- wr_uart  out  1  write strobe to the TX FIFO
- w_data  out  n_data_bits  byte to the TX FIFO
- tx_full  in  1  TX FIFO full
- busy  out  1  a grant is active
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- States: IDLE, GRANT. Registers: state, owner index, rr pointer (log2 n_req bits), stall counter.
- IDLE: if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo n_req. Load the owner and go to GRANT. If no req bit is set, stay in IDLE.
- GRANT: req_ready[owner] = ~tx_full. All other req_ready bits are 0.
- Transfer: req_valid[owner] & ~tx_full. On a transfer, wr_uart = 1 and w_data = the owner's byte.
- Transfer with req_last[owner]: go to IDLE and set the pointer to (owner+1) mod n_req.
- req[owner] deasserts mid-frame without last: abort the frame. Go to IDLE, advance the pointer the same way, and write nothing in that cycle.
- No preemption. Requests arriving during GRANT wait for the next IDLE arbitration.
- tx_full holds the transfer off indefinitely. The byte stays presented and nothing is lost or duplicated.
- Reset: state IDLE, pointer 0, counter 0. All outputs are 0, including grant, req_ready, wr_uart, w_data, busy and timeout_err.

## Timing
- wr_uart, w_data and req_ready are combinational from the registered state/owner and the current req_valid/tx_full. There is zero added latency per byte, and a full-rate stream of one byte per cycle is sustained.
- Request sampled in IDLE at cycle t: grant and busy are high at t+1.
- Last byte transfers at cycle t: IDLE at t+1, next grant at t+2 at the earliest. This gives a one-cycle gap between frames.
- A single-byte frame (valid & last on the first GRANT cycle) is legal.
- Reset asserted mid-frame: IDLE on the next edge. The remaining bytes are dropped and the TX FIFO is not touched.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - The counter increments each GRANT cycle with ~req_valid[owner] & ~tx_full, i.e. stalls caused by the requester.
  - The counter clears on a transfer and on entering GRANT.
  - When the counter reaches 2^n_timeout-1, the grant is revoked: go to IDLE, advance the pointer, and pulse timeout_err for one cycle.
  - Cycles with tx_full high never count.
- UART_ARB_TIMEOUT_EN undefined:
  - The counter is not built.
  - timeout_err is tied 0 and the port remains.
  - A stalled owner holds the grant forever.

## Structure
- Shared package uart_pkg holds:
  - the arbiter state enum (IDLE, GRANT);
  - the default widths n_data_bits = 8 and n_timeout = 10.
- Sub-module uart_rr_picker is combinational. Inputs: req and the pointer. Outputs: found flag and winning index. It can be reused by future RX-side schedulers.

## Test plan
- Single requester 1 sends a 3-byte frame 0x11, 0x22, 0x33 (last on 0x33), tx_full=0:
  - three consecutive wr_uart pulses with w_data 0x11, 0x22, 0x33;
  - grant=0010 for 3 cycles, then IDLE.
- All four req high at reset release, each sending a 2-byte frame:
  - grant order 0,1,2,3,0;
  - no byte interleaving between frames;
  - one-cycle gap between frames.
- tx_full held high for 5 cycles in the middle of a frame:
  - req_ready and wr_uart stay 0 for those 5 cycles;
  - the byte is written once after release;
  - timeout_err stays 0.
- Owner drops req after 1 of 3 bytes:
  - abort;
  - grant passes to the next pending requester at +2 cycles;
  - only 1 byte is written for the aborted frame.
- With UART_ARB_TIMEOUT_EN and n_timeout=4, the owner stalls with req high and req_valid low:
  - timeout_err pulses 15 cycles after the last activity;
  - the grant moves to the next requester.
- Reset asserted during a GRANT:
  - next cycle grant=0, busy=0, wr_uart=0;
  - arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state and the default byte and stall-counter widths.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned N_DATA_BITS = 8;
  localparam int unsigned N_TIMEOUT   = 10;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: the first set req bit at or after ptr, wrapping modulo n_req.
module uart_rr_picker #(
  parameter int unsigned n_req = 4,
  localparam int unsigned PtrW = (n_req > 1) ? $clog2(n_req) : 1
) (
  input  logic [n_req-1:0] req,
  input  logic [PtrW-1:0]  ptr,
  output logic             found,
  output logic [PtrW-1:0]  idx
);

  logic [PtrW-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    found = |req;
    idx   = '0;
    cand  = '0;
    for (int i = int'(n_req) - 1; i >= 0; i--) begin
      cand = PtrW'((int'(ptr) + i) % int'(n_req));
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter for the shared UART TX FIFO write port.
// Optional requester-stall timeout is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned n_req       = 4,
  parameter int unsigned n_data_bits = N_DATA_BITS,
  parameter int unsigned n_timeout   = N_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [n_req-1:0]             req,
  input  logic [n_req-1:0]             req_valid,
  input  logic [n_req*n_data_bits-1:0] req_data,
  input  logic [n_req-1:0]             req_last,
  output logic [n_req-1:0]             req_ready,
  output logic [n_req-1:0]             grant,
  output logic                         wr_uart,
  output logic [n_data_bits-1:0]       w_data,
  input  logic                         tx_full,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int unsigned PtrW = $clog2(n_req);
  localparam int unsigned DW   = n_data_bits;

  if (n_req < 2 || n_req > 8 || DW < 1 || n_timeout < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  arb_state_e      state_q, state_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] ptr_next;
  logic [PtrW-1:0] pick_idx;
  logic            pick_found;
  logic            active;
  logic            own_req, own_valid, own_last;
  logic            xfer;
  logic            revoke;
  logic [DW-1:0]   data_arr [n_req];
  logic [DW-1:0]   own_data;

  for (genvar g = 0; g < n_req; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  uart_rr_picker #(.n_req(n_req)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Reset also masks the datapath so a frame cut by reset never reaches the FIFO.
  assign active    = (state_q == GRANT) & ~reset;
  assign own_req   = req[owner_q];
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_data  = data_arr[owner_q];
  assign xfer      = active & own_req & own_valid & ~tx_full;
  assign ptr_next  = (owner_q == PtrW'(n_req - 1)) ? '0 : owner_q + PtrW'(1);

  assign busy      = active;
  assign grant     = active ? (n_req'(1) << owner_q) : '0;
  assign req_ready = (active & own_req & ~tx_full) ? grant : '0;
  assign wr_uart   = xfer;
  assign w_data    = xfer ? own_data : '0;

`ifdef UART_ARB_TIMEOUT_EN
  // Revoke on the stall that would bring the counter to its all-ones value.
  localparam logic [n_timeout-1:0] CntRevoke = {{(n_timeout-1){1'b1}}, 1'b0};

  logic [n_timeout-1:0] cnt_q, cnt_d;
  logic                 stall;

  assign stall       = active & own_req & ~own_valid & ~tx_full;
  assign revoke      = stall & (cnt_q == CntRevoke);
  assign timeout_err = revoke;

  always_comb begin
    cnt_d = cnt_q;
    if (!active || xfer || revoke) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + n_timeout'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign revoke      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        // Frame end, abort (req dropped) and timeout all release the grant alike.
        if (!own_req || (xfer && own_last) || revoke) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with the default 4-requester, 8-bit configuration.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_valid, req_last;
  logic [31:0] req_data;
  logic        tx_full;
  logic [3:0]  req_ready, grant;
  logic        wr_uart, busy, timeout_err;
  logic [7:0]  w_data;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .tx_full     (tx_full),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle before checking.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] v,
                     input logic [3:0] l, input logic [31:0] d, input logic full);
    @(negedge clk);
    reset     = rst;
    req       = r;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    tx_full   = full;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                            input logic wr, input logic [7:0] wd);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".wr"}, 32'(wr_uart), 32'(wr));
    chk({tag, ".terr"}, 32'(timeout_err), 32'(0));
    if (wr) chk({tag, ".wdata"}, 32'(w_data), 32'(wd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [3:0]  gseq [15];
  int          idx [4];
  logic [31:0] d;
  logic [3:0]  l;
  logic [7:0]  wd;

  initial begin
    reset = 1'b1; req = '0; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;

    // Reset state
    cyc(1, 4'h0, 4'h0, 4'h0, 32'h0, 0);
    cyc(1, 4'h0, 4'h0, 4'h0, 32'h0, 0);
    expect_out("rst", 4'h0, 4'h0, 0, 8'h00);
    chk("rst.wdata", 32'(w_data), 32'h0);

    // Requester 1 sends 0x11 0x22 0x33
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_1100, 0); expect_out("b0", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_1100, 0); expect_out("b1", 4'b0010, 4'b0010, 1, 8'h11);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_2200, 0); expect_out("b2", 4'b0010, 4'b0010, 1, 8'h22);
    cyc(0, 4'b0010, 4'b0010, 4'b0010, 32'h0000_3300, 0); expect_out("b3", 4'b0010, 4'b0010, 1, 8'h33);
    cyc(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 0);         expect_out("b4", 4'h0, 4'h0, 0, 8'h00);

    // All four request at reset release, 2-byte frames, order 0,1,2,3,0
    cyc(1, 4'hF, 4'hF, 4'h0, 32'h0, 0);
    expect_out("rst2", 4'h0, 4'h0, 0, 8'h00);
    gseq = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
             4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    foreach (idx[i]) idx[i] = 0;
    for (int c = 0; c < 15; c++) begin
      wd = '0;
      for (int i = 0; i < 4; i++) begin
        d[i*8 +: 8] = 8'(16 * (i + 1) + idx[i]);
        l[i]        = (idx[i] % 2) == 1;
        if (gseq[c][i]) wd = d[i*8 +: 8];
      end
      cyc(0, 4'hF, 4'hF, l, d, 0);
      expect_out($sformatf("rr%0d", c), gseq[c], gseq[c], gseq[c] != 4'h0, wd);
      for (int i = 0; i < 4; i++) if (gseq[c][i]) idx[i]++;
    end
    cyc(0, 4'h0, 4'h0, 4'h0, 32'h0, 0); expect_out("rr_end", 4'h0, 4'h0, 0, 8'h00);

    // Requester 2 frame with tx_full held for 5 cycles mid-frame
    cyc(0, 4'b0100, 4'b0100, 4'h0, 32'h0051_0000, 0); expect_out("f0", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0100, 4'b0100, 4'h0, 32'h0051_0000, 0); expect_out("f1", 4'b0100, 4'b0100, 1, 8'h51);
    for (int c = 0; c < 5; c++) begin
      cyc(0, 4'b0100, 4'b0100, 4'h0, 32'h0052_0000, 1);
      expect_out($sformatf("full%0d", c), 4'b0100, 4'h0, 0, 8'h00);
    end
    cyc(0, 4'b0100, 4'b0100, 4'h0,    32'h0052_0000, 0); expect_out("f7", 4'b0100, 4'b0100, 1, 8'h52);
    cyc(0, 4'b0100, 4'b0100, 4'b0100, 32'h0053_0000, 0); expect_out("f8", 4'b0100, 4'b0100, 1, 8'h53);
    cyc(0, 4'h0, 4'h0, 4'h0, 32'h0, 0);                  expect_out("f9", 4'h0, 4'h0, 0, 8'h00);

    // Requester 3 aborts after one byte; requester 0 (wrapped) is next
    cyc(0, 4'b1001, 4'b1001, 4'b0001, 32'h6100_0071, 0); expect_out("a0", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b1001, 4'b1001, 4'b0001, 32'h6100_0071, 0); expect_out("a1", 4'b1000, 4'b1000, 1, 8'h61);
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 32'h0000_0071, 0);
    chk("a2.grant", 32'(grant), 32'(4'b1000));
    chk("a2.wr", 32'(wr_uart), 32'(0));
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 32'h0000_0071, 0); expect_out("a3", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 32'h0000_0071, 0); expect_out("a4", 4'b0001, 4'b0001, 1, 8'h71);
    cyc(0, 4'h0, 4'h0, 4'h0, 32'h0, 0);                  expect_out("a5", 4'h0, 4'h0, 0, 8'h00);

    // Reset during requester 1's grant; arbitration restarts from requester 0
    cyc(0, 4'b0010, 4'b0010, 4'h0, 32'h0000_8100, 0); expect_out("r0", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0010, 4'b0010, 4'h0, 32'h0000_8100, 0); expect_out("r1", 4'b0010, 4'b0010, 1, 8'h81);
    cyc(1, 4'b0011, 4'b0011, 4'b0001, 32'h0000_8291, 0);
    cyc(0, 4'b0011, 4'b0011, 4'b0001, 32'h0000_8291, 0); expect_out("r3", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0011, 4'b0011, 4'b0001, 32'h0000_8291, 0); expect_out("r4", 4'b0001, 4'b0001, 1, 8'h91);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_8200, 0); expect_out("r5", 4'h0, 4'h0, 0, 8'h00);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 32'h0000_8200, 0); expect_out("r6", 4'b0010, 4'b0010, 1, 8'h82);
    cyc(1, 4'h0, 4'h0, 4'h0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
